// File: rtl/fft_out_sorter.sv
// Reorders bit-reversed 32-point FFT output into natural frequency order.
// Ping-pong storage lets one frame be written while the other streams out.
module fft_out_sorter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [17:0] X_r,
  input  logic [17:0] X_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [17:0] Y_r,
  output logic [17:0] Y_i,
  output logic [4:0]  idx_o,
  output logic        last_o,
  output logic        ovf_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, READ = 1'b1} state_t;

  function automatic logic [4:0] bitrev5(input logic [4:0] a);
    return {a[0], a[1], a[2], a[3], a[4]};
  endfunction

  // Address is {bank, entry}; each entry holds {real, imag}.
  logic [35:0] mem_r [0:63];

  state_t      state_r, state_s;
  logic [4:0]  wr_cnt_r, wr_cnt_s;
  logic [4:0]  rd_cnt_r, rd_cnt_s;
  logic        wr_bank_r, wr_bank_s;
  logic        rd_bank_r, rd_bank_s;
  logic [1:0]  full_r, full_s;
  logic        ovf_s;
  logic        valid_s, last_s;
  logic [4:0]  idx_s;
  logic [17:0] yr_s, yi_s;
  logic        wr_en_s;
  logic        accept_s;

  assign wr_en_s  = valid_i && !full_r[wr_bank_r];
  assign accept_s = valid_o && ready_i;

  // Sample capture into the write bank at the bit-reversed address.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[{wr_bank_r, bitrev5(wr_cnt_r)}] <= {X_r, X_i};
    end
  end

  // Next-state for write counters, full flags, read FSM and output register.
  always_comb begin
    wr_cnt_s  = wr_cnt_r;
    wr_bank_s = wr_bank_r;
    full_s    = full_r;
    ovf_s     = ovf_o;
    state_s   = state_r;
    rd_cnt_s  = rd_cnt_r;
    rd_bank_s = rd_bank_r;
    valid_s   = valid_o;
    last_s    = last_o;
    idx_s     = idx_o;
    yr_s      = Y_r;
    yi_s      = Y_i;

    if (valid_i && full_r[wr_bank_r]) begin
      ovf_s = 1'b1;
    end else if (valid_i) begin
      wr_cnt_s = wr_cnt_r + 5'd1;
      if (wr_cnt_r == 5'd31) begin
        full_s[wr_bank_r] = 1'b1;
        wr_bank_s         = ~wr_bank_r;
      end else begin
        wr_bank_s = wr_bank_r;
      end
    end else begin
      ovf_s = ovf_o;
    end

    // The writer only completes a non-full bank and the reader only releases a full one,
    // so the set and clear below never collide on the same flag.
    case (state_r)
      IDLE: begin
        if (full_r[rd_bank_r]) begin
          state_s  = READ;
          rd_cnt_s = 5'd0;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (accept_s && last_o) begin
          full_s[rd_bank_r] = 1'b0;
          rd_bank_s         = ~rd_bank_r;
          if (full_r[~rd_bank_r]) begin
            {yr_s, yi_s} = mem_r[{~rd_bank_r, 5'd0}];
            idx_s        = 5'd0;
            last_s       = 1'b0;
            valid_s      = 1'b1;
            rd_cnt_s     = 5'd1;
          end else begin
            state_s  = IDLE;
            valid_s  = 1'b0;
            last_s   = 1'b0;
            rd_cnt_s = 5'd0;
          end
        end else if (!valid_o || (ready_i && !last_o)) begin
          {yr_s, yi_s} = mem_r[{rd_bank_r, rd_cnt_r}];
          idx_s        = rd_cnt_r;
          last_s       = (rd_cnt_r == 5'd31);
          valid_s      = 1'b1;
          rd_cnt_s     = rd_cnt_r + 5'd1;
        end else begin
          valid_s = valid_o;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      wr_cnt_r  <= 5'd0;
      wr_bank_r <= 1'b0;
      rd_cnt_r  <= 5'd0;
      rd_bank_r <= 1'b0;
      full_r    <= 2'b00;
      ovf_o     <= 1'b0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      idx_o     <= 5'd0;
      Y_r       <= 18'd0;
      Y_i       <= 18'd0;
    end else begin
      state_r   <= state_s;
      wr_cnt_r  <= wr_cnt_s;
      wr_bank_r <= wr_bank_s;
      rd_cnt_r  <= rd_cnt_s;
      rd_bank_r <= rd_bank_s;
      full_r    <= full_s;
      ovf_o     <= ovf_s;
      valid_o   <= valid_s;
      last_o    <= last_s;
      idx_o     <= idx_s;
      Y_r       <= yr_s;
      Y_i       <= yi_s;
    end
  end

endmodule

// File: tb/tb_fft_out_sorter.sv
// Directed bench for fft_out_sorter: ordering, latency, back-to-back, backpressure,
// overflow, mid-frame reset and gapped input.
module tb_fft_out_sorter;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic [17:0] X_r;
  logic [17:0] X_i;
  logic        ready_i;
  logic        valid_o;
  logic [17:0] Y_r;
  logic [17:0] Y_i;
  logic [4:0]  idx_o;
  logic        last_o;
  logic        ovf_o;

  fft_out_sorter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .X_r     (X_r),
    .X_i     (X_i),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .Y_r     (Y_r),
    .Y_i     (Y_i),
    .idx_o   (idx_o),
    .last_o  (last_o),
    .ovf_o   (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  idx;
    logic [17:0] yr;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          gaps     = 0;
  logic        seen     = 1'b0;
  logic        stall_prev = 1'b0;
  logic [17:0] held_yr, held_yi;
  logic [4:0]  held_idx;
  logic        held_last;

  function automatic logic [4:0] br5(input logic [4:0] a);
    return {a[0], a[1], a[2], a[3], a[4]};
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output n of a frame comes from input position bitrev5(n).
  task automatic push_frame(input logic [17:0] base);
    exp_t e;
    for (int n = 0; n < 32; n++) begin
      e.idx = 5'(n);
      e.yr  = base + 18'(br5(5'(n)));
      q.push_back(e);
    end
  endtask

  // Drive one cycle of inputs, score the beat handshaken at the coming edge, then advance.
  task automatic cycle(input logic vi, input logic [17:0] xr, input logic rdy);
    exp_t e;
    valid_i = vi;
    X_r     = vi ? xr : 18'd0;
    X_i     = vi ? 18'(18'd0 - xr) : 18'd0;
    ready_i = rdy;
    if (stall_prev) begin
      chk("hold_valid", 36'(valid_o), 36'(1'b1));
      chk("hold_yr",    36'(Y_r),     36'(held_yr));
      chk("hold_yi",    36'(Y_i),     36'(held_yi));
      chk("hold_idx",   36'(idx_o),   36'(held_idx));
      chk("hold_last",  36'(last_o),  36'(held_last));
    end
    if (valid_o && rdy) begin
      if (q.size() == 0) begin
        chk("extra_beat", 36'(valid_o), 36'(1'b0));
      end else begin
        e = q.pop_front();
        chk("idx",  36'(idx_o),  36'(e.idx));
        chk("y_r",  36'(Y_r),    36'(e.yr));
        chk("y_i",  36'(Y_i),    36'(18'(18'd0 - e.yr)));
        chk("last", 36'(last_o), 36'(e.idx == 5'd31));
      end
    end
    if (seen && q.size() != 0 && !valid_o) gaps++;
    if (valid_o) seen = 1'b1;
    stall_prev = valid_o && !rdy;
    held_yr    = Y_r;
    held_yi    = Y_i;
    held_idx   = idx_o;
    held_last  = last_o;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [17:0] base, input int gap, input logic rdy);
    for (int k = 0; k < 32; k++) begin
      cycle(1'b1, base + 18'(k), rdy);
      if (k != 31) repeat (gap) cycle(1'b0, 18'd0, rdy);
    end
  endtask

  // toggle=1 drives ready 1,0,1,0...; all expected beats must drain within the budget.
  task automatic drain(input logic toggle);
    int k;
    k = 0;
    while (q.size() != 0 && k < 400) begin
      cycle(1'b0, 18'd0, toggle ? (k % 2 == 0) : 1'b1);
      k++;
    end
    chk("drain_left", 36'(q.size()), 36'(0));
    repeat (4) cycle(1'b0, 18'd0, 1'b1);
    chk("idle_valid", 36'(valid_o), 36'(1'b0));
  endtask

  task automatic latency_check(input logic [17:0] base);
    chk("lat_e0_valid", 36'(valid_o), 36'(1'b0));
    cycle(1'b0, 18'd0, 1'b1);
    chk("lat_e1_valid", 36'(valid_o), 36'(1'b0));
    cycle(1'b0, 18'd0, 1'b1);
    chk("lat_e2_valid", 36'(valid_o), 36'(1'b1));
    chk("lat_e2_idx",   36'(idx_o),   36'(5'd0));
    chk("lat_e2_yr",    36'(Y_r),     36'(base));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 36'(valid_o), 36'(1'b0));
    chk({tag, "_yr"},    36'(Y_r),     36'(18'd0));
    chk({tag, "_yi"},    36'(Y_i),     36'(18'd0));
    chk({tag, "_idx"},   36'(idx_o),   36'(5'd0));
    chk({tag, "_last"},  36'(last_o),  36'(1'b0));
    chk({tag, "_ovf"},   36'(ovf_o),   36'(1'b0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    X_r     = 18'd0;
    X_i     = 18'd0;
    ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame, contiguous; input k = (k, -k)
    push_frame(18'd0);
    send_frame(18'd0, 0, 1'b1);
    latency_check(18'd0);
    drain(1'b0);

    // Back-to-back frames: no bubble, no overflow
    push_frame(18'd0);
    push_frame(18'd100);
    gaps = 0;
    seen = 1'b0;
    send_frame(18'd0, 0, 1'b1);
    send_frame(18'd100, 0, 1'b1);
    drain(1'b0);
    chk("b2b_gaps", 36'(gaps), 36'(0));
    chk("b2b_ovf",  36'(ovf_o), 36'(1'b0));

    // Backpressure: ready toggles during readout
    push_frame(18'd50);
    send_frame(18'd50, 0, 1'b1);
    drain(1'b1);

    // Overflow: ready low for 96 inputs, third frame dropped
    push_frame(18'd0);
    push_frame(18'd200);
    send_frame(18'd0, 0, 1'b0);
    send_frame(18'd200, 0, 1'b0);
    chk("ovf_before", 36'(ovf_o), 36'(1'b0));
    cycle(1'b1, 18'd400, 1'b0);
    chk("ovf_first_drop", 36'(ovf_o), 36'(1'b1));
    for (int k = 1; k < 32; k++) cycle(1'b1, 18'd400 + 18'(k), 1'b0);
    chk("ovf_hold_valid", 36'(valid_o), 36'(1'b1));
    chk("ovf_hold_idx",   36'(idx_o),   36'(5'd0));
    chk("ovf_hold_yr",    36'(Y_r),     36'(18'd0));
    drain(1'b0);
    chk("ovf_sticky", 36'(ovf_o), 36'(1'b1));

    // Reset after 20 inputs of a frame
    for (int k = 0; k < 20; k++) cycle(1'b1, 18'd500 + 18'(k), 1'b1);
    valid_i = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    check_zero("midrst_edge");
    rst_n      = 1'b1;
    stall_prev = 1'b0;
    push_frame(18'd600);
    send_frame(18'd600, 0, 1'b1);
    latency_check(18'd600);
    drain(1'b0);
    chk("post_rst_ovf", 36'(ovf_o), 36'(1'b0));

    // Gapped input: one sample every third cycle
    push_frame(18'd0);
    send_frame(18'd0, 2, 1'b1);
    latency_check(18'd0);
    drain(1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_out_sorter.md
FFT_OUT_SORTER -- requirements
Module: fft_out_sorter

Interface
REQ-001 Parameters: none; frame length fixed at 32 points, sample width fixed at 18 bits signed.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 valid_i  input  1  driven by the FFT core's finish; high = X_r/X_i carry one valid FFT output this cycle.
REQ-005 X_r  input  18  real part of the FFT output, arriving in bit-reversed order.
REQ-006 X_i  input  18  imaginary part of the FFT output, arriving in bit-reversed order.
REQ-007 ready_i  input  1  downstream consumer can accept Y_r/Y_i this cycle.
REQ-008 valid_o  output  1  Y_r, Y_i, idx_o and last_o are valid.
REQ-009 Y_r  output  18  real part, natural frequency order.
REQ-010 Y_i  output  18  imaginary part, natural frequency order.
REQ-011 idx_o  output  5  natural frequency index of the current output (0..31).
REQ-012 last_o  output  1  high together with valid_o when idx_o==31.
REQ-013 ovf_o  output  1  sticky; set when an input sample is dropped.

Function
REQ-014 Storage: two banks (ping-pong) of 32 x 36-bit entries (X_r concatenated with X_i).
REQ-015 Write side:
- 5-bit wr_cnt and 1-bit wr_bank.
- Each cycle with valid_i high, write {X_r,X_i} to bank wr_bank at address bitrev5(wr_cnt), with bit order reversed (b4..b0 -> b0..b4), then increment wr_cnt.
REQ-016 valid_i may be non-contiguous within a frame; gaps do not affect wr_cnt.
REQ-017 Frame completion: on the capture with wr_cnt==31, wr_cnt wraps to 0, full[wr_bank] is set, and wr_bank toggles.
REQ-018 Overflow:
- If valid_i is high while full[wr_bank]==1, the sample is dropped and wr_cnt does not change.
- ovf_o is set and stays high until reset.
REQ-019 Read FSM:
- States: IDLE and READ; 1-bit rd_bank and 5-bit rd_cnt.
- IDLE -> READ when full[rd_bank]==1, with rd_cnt=0.
REQ-020 Output register:
- In READ, load bank[rd_bank][rd_cnt] into Y_r/Y_i, with idx_o=rd_cnt and valid_o=1, whenever the output register is empty or being accepted (valid_o&&ready_i).
- Increment rd_cnt on each load.
REQ-021 Hold: while valid_o && !ready_i, Y_r, Y_i, idx_o, last_o and valid_o stay stable.
REQ-022 Frame release:
- When the beat with idx_o==31 is accepted, clear full[rd_bank] and toggle rd_bank.
- If the other bank is full, load its index 0 on the same edge (no bubble); otherwise go to IDLE and clear valid_o on that edge.
REQ-023 Latency: with ready_i held high, valid_o with idx_o=0 first appears 2 rising edges after the edge that captured input sample 31; after that, one output every cycle.
REQ-024 Simultaneous events: in the same cycle, a write that sets full[x] and a read release that clears full[y] (x!=y) both take effect. A read and a write never target the same bank.
REQ-025 Data passes through unmodified: no rounding, scaling or sign change.

Reset
REQ-026 While rst_n==0, all of the following are 0: valid_o, Y_r, Y_i, idx_o, last_o, ovf_o, wr_cnt, rd_cnt, wr_bank, rd_bank, both full flags; FSM is IDLE.
REQ-027 A reset asserted mid-frame discards partial and complete frames. Bank RAM contents need no reset.
REQ-028 After rst_n deasserts, the first valid_i sample is treated as input position 0.

Verification
REQ-029 Single frame: 32 contiguous inputs with input k carrying X_r=k, X_i=-k (ready_i=1) -> outputs idx 0..31 in order; output n has Y_r=bitrev5(n), Y_i=-bitrev5(n); first valid_o 2 edges after the last input; last_o only on idx 31.
REQ-030 Back-to-back frames: 64 contiguous inputs (frame A values 0..31, frame B values 100..131) -> 64 contiguous outputs with no bubble; ovf_o stays 0.
REQ-031 Backpressure: ready_i toggles 1,0,1,0... during readout -> every idx 0..31 appears exactly once, data stable across stalls, no loss.
REQ-032 Overflow: ready_i=0 for the whole run and 96 inputs -> first 64 stored, third frame dropped, ovf_o=1 from the first dropped sample. After ready_i=1, 64 outputs = frames 1 and 2.
REQ-033 Reset mid-operation: assert rst_n=0 after 20 inputs of a frame, release, then send a full frame -> all outputs 0 during reset; afterwards exactly 32 outputs carrying only the post-reset frame.
REQ-034 Gapped input: valid_i high every third cycle for 32 samples -> same ordered output as REQ-029, starting 2 edges after the 32nd sample.
